if_stage: RTL and testbench

//  Instruction-fetch stage feeding the decode stage: owns the fetch PC and issues one request at a time on the instruction-SRAM bus.

---
 rtl/if_stage_pkg.sv | 21 ++
 rtl/if_next_pc.sv | 33 +++
 rtl/if_stage.sv | 132 +++++++++++++
 tb/tb_if_stage.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: pcsource codes, exception bits, FSM states.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC00000;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam int          EXC_W         = 7;
    localparam int          EXC_ADEL_IF   = 6;
    localparam logic [6:0]  EXC_ADEL_MASK = 7'h40;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_FULL = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_next_pc.sv
// Next fetch PC selection: sequential pc+4 or the redirect target held over the delay slot.
module if_next_pc
    import if_stage_pkg::*;
(
    input  logic [31:0] pc_f,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jrpc,
    input  logic [31:0] jpc,
    input  logic        br_pending,
    input  logic [31:0] br_target,
    output logic [31:0] pc_next,
    output logic [31:0] redirect_target,
    output logic        redirect_taken
);

    logic [31:0] pc_seq;

    assign pc_seq         = pc_f + 32'd4;
    assign redirect_taken = (pcsource != PCSRC_SEQ);
    assign pc_next        = br_pending ? br_target : pc_seq;

    always_comb begin
        redirect_target = pc_seq;
        case (pcsource)
            PCSRC_BR: redirect_target = bpc;
            PCSRC_JR: redirect_target = jrpc;
            PCSRC_J:  redirect_target = jpc;
            default:  redirect_target = pc_seq;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: single-outstanding SRAM fetch FSM and IF/ID register.
// Optional fetch address-error detection is enabled by defining IF_ADEL_CHECK_EN.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok,
    input  logic        id_allowin,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] jrpc,
    input  logic        next_is_delayslot,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [6:0]  o_except,
    output logic        o_bd
);

    fetch_state_e state, state_n;
    logic [31:0]  pc_f, br_target, pc_next, redirect_target;
    logic         br_pending, bd_next, discard, redirect_taken;
    logic         transfer, misaligned, data_accept, adel_load, discard_set;

    if_next_pc u_next_pc (
        .pc_f            (pc_f),
        .pcsource        (pcsource),
        .bpc             (bpc),
        .jrpc            (jrpc),
        .jpc             (jpc),
        .br_pending      (br_pending),
        .br_target       (br_target),
        .pc_next         (pc_next),
        .redirect_target (redirect_target),
        .redirect_taken  (redirect_taken)
    );

    assign inst_addr = {pc_f[31:2], 2'b00};
    assign transfer  = o_valid & id_allowin;

`ifdef IF_ADEL_CHECK_EN
    assign misaligned = (pc_f[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign data_accept = (state == ST_WAIT) && inst_data_ok && !discard && !flush;
    assign adel_load   = (state == ST_REQ) && misaligned && !flush;

    // A flush abandons a request the bus has already taken; its data must be swallowed.
    assign discard_set = flush && (((state == ST_WAIT) && !inst_data_ok) ||
                                   (inst_req && inst_addr_ok));

    always_comb begin
        state_n  = state;
        inst_req = 1'b0;
        case (state)
            ST_REQ: begin
                if (misaligned) begin
                    state_n = ST_FULL;
                end else if (!discard) begin
                    inst_req = 1'b1;
                    if (inst_addr_ok) state_n = ST_WAIT;
                end
            end
            ST_WAIT: if (inst_data_ok && !discard) state_n = ST_FULL;
            ST_FULL: if (transfer) state_n = ST_REQ;
            default: state_n = ST_REQ;
        endcase
        if (flush) state_n = ST_REQ;
        if (reset) inst_req = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_REQ;
            pc_f       <= RESET_PC;
            br_pending <= 1'b0;
            br_target  <= 32'd0;
            bd_next    <= 1'b0;
            discard    <= 1'b0;
            o_valid    <= 1'b0;
            o_inst     <= 32'd0;
            o_pc       <= 32'd0;
            o_except   <= '0;
            o_bd       <= 1'b0;
        end else begin
            state   <= state_n;
            discard <= discard_set | (discard & ~inst_data_ok);
            if (flush) begin
                o_valid    <= 1'b0;
                pc_f       <= flush_pc;
                br_pending <= 1'b0;
                bd_next    <= 1'b0;
            end else if (data_accept) begin
                o_valid  <= 1'b1;
                o_inst   <= inst_rdata;
                o_pc     <= pc_f;
                o_except <= '0;
                o_bd     <= bd_next;
            end else if (adel_load) begin
                o_valid  <= 1'b1;
                o_inst   <= 32'd0;
                o_pc     <= pc_f;
                o_except <= EXC_ADEL_MASK;
                o_bd     <= bd_next;
            end else if (transfer) begin
                // The branch itself moves on to its delay slot; the delay slot moves to the target.
                o_valid <= 1'b0;
                pc_f    <= pc_next;
                bd_next <= next_is_delayslot;
                if (br_pending) begin
                    br_pending <= 1'b0;
                end else if (redirect_taken) begin
                    br_pending <= 1'b1;
                    br_target  <= redirect_target;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage, plus a randomised-latency run against a PC model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic [31:0] inst_rdata = 32'd0;
    logic        inst_data_ok = 1'b0;
    logic        id_allowin = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = 32'd0;
    logic [31:0] jpc = 32'd0;
    logic [31:0] jrpc = 32'd0;
    logic        next_is_delayslot = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'd0;
    logic        o_valid;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic [6:0]  o_except;
    logic        o_bd;

    int assertions = 0;
    int failures = 0;
    int req_in_wait = 0;

    if_stage dut (
        .clk               (clk),
        .reset             (reset),
        .inst_req          (inst_req),
        .inst_addr         (inst_addr),
        .inst_addr_ok      (inst_addr_ok),
        .inst_rdata        (inst_rdata),
        .inst_data_ok      (inst_data_ok),
        .id_allowin        (id_allowin),
        .pcsource          (pcsource),
        .bpc               (bpc),
        .jpc               (jpc),
        .jrpc              (jrpc),
        .next_is_delayslot (next_is_delayslot),
        .flush             (flush),
        .flush_pc          (flush_pc),
        .o_valid           (o_valid),
        .o_inst            (o_inst),
        .o_pc              (o_pc),
        .o_except          (o_except),
        .o_bd              (o_bd)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        if (a == 32'hBFC00000) return 32'h24010001;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory side of one fetch: wait for a request, accept it, return data after the given delays.
    task automatic serve(input int ad, input int dd);
        int n;
        logic [31:0] req_addr;
        n = 0;
        while (!inst_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!inst_req) begin
            assertions++; failures++;
            $display("[TB] FAIL serve_timeout: inst_req got %b required 1", inst_req);
            return;
        end
        repeat (ad) @(negedge clk);
        req_addr = inst_addr;
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0;
        repeat (dd) begin
            if (inst_req) req_in_wait++;
            @(negedge clk);
        end
        if (inst_req) req_in_wait++;
        inst_rdata = inst_of(req_addr);
        inst_data_ok = 1'b1;
        @(negedge clk);
        inst_data_ok = 1'b0;
    endtask

    task automatic pass_to_decode(input logic [1:0] ps, input logic nds);
        pcsource = ps;
        next_is_delayslot = nds;
        id_allowin = 1'b1;
        @(negedge clk);
        id_allowin = 1'b0;
        pcsource = 2'b00;
        next_is_delayslot = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        assertions++; if (inst_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req: got %b required 0", inst_req); end
        assertions++; if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b required 0", o_valid); end
        assertions++; if (o_inst !== 32'd0) begin failures++; $display("[TB] FAIL reset_inst: got %h required 0", o_inst); end
        assertions++; if (o_pc !== 32'd0) begin failures++; $display("[TB] FAIL reset_pc: got %h required 0", o_pc); end
        assertions++; if (o_except !== 7'd0) begin failures++; $display("[TB] FAIL reset_except: got %h required 0", o_except); end
        assertions++; if (o_bd !== 1'b0) begin failures++; $display("[TB] FAIL reset_bd: got %b required 0", o_bd); end
        reset = 1'b0;
        @(negedge clk);
        assertions++; if (inst_req !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_req: got %b required 1", inst_req); end
        assertions++; if (inst_addr !== 32'hBFC00000) begin failures++; $display("[TB] FAIL post_reset_addr: got %h required bfc00000", inst_addr); end
    endtask

    task automatic test_first_fetch();
        serve(1, 2);
        assertions++; if (o_valid !== 1'b1) begin failures++; $display("[TB] FAIL first_valid: got %b required 1", o_valid); end
        assertions++; if (o_pc !== 32'hBFC00000) begin failures++; $display("[TB] FAIL first_pc: got %h required bfc00000", o_pc); end
        assertions++; if (o_inst !== 32'h24010001) begin failures++; $display("[TB] FAIL first_inst: got %h required 24010001", o_inst); end
        assertions++; if (o_bd !== 1'b0) begin failures++; $display("[TB] FAIL first_bd: got %b required 0", o_bd); end
        assertions++; if (o_except !== 7'd0) begin failures++; $display("[TB] FAIL first_except: got %h required 0", o_except); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            assertions++; if (o_valid !== 1'b1 || o_pc !== 32'hBFC00000 || o_inst !== 32'h24010001) begin
                failures++; $display("[TB] FAIL stall_hold: got v=%b pc=%h inst=%h required v=1 pc=bfc00000 inst=24010001", o_valid, o_pc, o_inst);
            end
            assertions++; if (inst_req !== 1'b0) begin failures++; $display("[TB] FAIL stall_req: got %b required 0", inst_req); end
        end
        pass_to_decode(2'b00, 1'b0);
        assertions++; if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL stall_release_valid: got %b required 0", o_valid); end
        assertions++; if (inst_req !== 1'b1) begin failures++; $display("[TB] FAIL stall_release_req: got %b required 1", inst_req); end
        assertions++; if (inst_addr !== 32'hBFC00004) begin failures++; $display("[TB] FAIL stall_release_addr: got %h required bfc00004", inst_addr); end
    endtask

    task automatic test_branch_delay_slot();
        for (int i = 0; i < 3; i++) begin
            serve(0, 0);
            pass_to_decode(2'b00, 1'b0);
        end
        serve(2, 1);
        assertions++; if (o_pc !== 32'hBFC00010) begin failures++; $display("[TB] FAIL br_pc: got %h required bfc00010", o_pc); end
        bpc = 32'hBFC00100;
        pass_to_decode(2'b01, 1'b1);
        assertions++; if (inst_addr !== 32'hBFC00014) begin failures++; $display("[TB] FAIL ds_addr: got %h required bfc00014", inst_addr); end
        serve(0, 3);
        assertions++; if (o_pc !== 32'hBFC00014) begin failures++; $display("[TB] FAIL ds_pc: got %h required bfc00014", o_pc); end
        assertions++; if (o_bd !== 1'b1) begin failures++; $display("[TB] FAIL ds_bd: got %b required 1", o_bd); end
        pass_to_decode(2'b00, 1'b0);
        assertions++; if (inst_addr !== 32'hBFC00100) begin failures++; $display("[TB] FAIL target_addr: got %h required bfc00100", inst_addr); end
        serve(1, 0);
        assertions++; if (o_pc !== 32'hBFC00100) begin failures++; $display("[TB] FAIL target_pc: got %h required bfc00100", o_pc); end
        assertions++; if (o_bd !== 1'b0) begin failures++; $display("[TB] FAIL target_bd: got %b required 0", o_bd); end
        assertions++; if (o_inst !== 32'h0100FEFF) begin failures++; $display("[TB] FAIL target_inst: got %h required 0100feff", o_inst); end
        pass_to_decode(2'b00, 1'b0);
    endtask

    task automatic test_flush_wait();
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0;
        flush = 1'b1;
        flush_pc = 32'hBFC00380;
        @(negedge clk);
        flush = 1'b0;
        assertions++; if (inst_req !== 1'b0) begin failures++; $display("[TB] FAIL discard_req: got %b required 0", inst_req); end
        @(negedge clk);
        inst_rdata = 32'hDEADBEEF;
        inst_data_ok = 1'b1;
        @(negedge clk);
        inst_data_ok = 1'b0;
        assertions++; if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL stale_valid: got %b required 0", o_valid); end
        assertions++; if (inst_req !== 1'b1) begin failures++; $display("[TB] FAIL flush_req: got %b required 1", inst_req); end
        assertions++; if (inst_addr !== 32'hBFC00380) begin failures++; $display("[TB] FAIL flush_addr: got %h required bfc00380", inst_addr); end
        serve(0, 1);
        assertions++; if (o_pc !== 32'hBFC00380 || o_inst !== 32'h0380FC7F) begin
            failures++; $display("[TB] FAIL flush_fetch: got pc=%h inst=%h required pc=bfc00380 inst=0380fc7f", o_pc, o_inst);
        end
    endtask

    task automatic test_flush_with_transfer();
        jpc = 32'hBFC00500;
        pcsource = 2'b11;
        next_is_delayslot = 1'b1;
        id_allowin = 1'b1;
        flush = 1'b1;
        flush_pc = 32'hBFC00200;
        @(negedge clk);
        flush = 1'b0;
        id_allowin = 1'b0;
        pcsource = 2'b00;
        next_is_delayslot = 1'b0;
        assertions++; if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL ft_valid: got %b required 0", o_valid); end
        assertions++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00200) begin
            failures++; $display("[TB] FAIL ft_req: got req=%b addr=%h required req=1 addr=bfc00200", inst_req, inst_addr);
        end
        serve(1, 1);
        assertions++; if (o_pc !== 32'hBFC00200 || o_bd !== 1'b0) begin
            failures++; $display("[TB] FAIL ft_fetch: got pc=%h bd=%b required pc=bfc00200 bd=0", o_pc, o_bd);
        end
        pass_to_decode(2'b00, 1'b0);
        assertions++; if (inst_addr !== 32'hBFC00204) begin failures++; $display("[TB] FAIL ft_no_jump: got %h required bfc00204", inst_addr); end
    endtask

    task automatic test_misaligned_jr();
        serve(0, 0);
        jrpc = 32'hBFC00102;
        pass_to_decode(2'b10, 1'b1);
        serve(0, 0);
        assertions++; if (o_pc !== 32'hBFC00208 || o_bd !== 1'b1) begin
            failures++; $display("[TB] FAIL jr_ds: got pc=%h bd=%b required pc=bfc00208 bd=1", o_pc, o_bd);
        end
        pass_to_decode(2'b00, 1'b0);
`ifdef IF_ADEL_CHECK_EN
        assertions++; if (inst_req !== 1'b0) begin failures++; $display("[TB] FAIL adel_req: got %b required 0", inst_req); end
        @(negedge clk);
        assertions++; if (inst_req !== 1'b0) begin failures++; $display("[TB] FAIL adel_req_full: got %b required 0", inst_req); end
        assertions++; if (o_valid !== 1'b1 || o_except !== 7'h40) begin
            failures++; $display("[TB] FAIL adel_except: got v=%b exc=%h required v=1 exc=40", o_valid, o_except);
        end
        assertions++; if (o_pc !== 32'hBFC00102 || o_inst !== 32'd0 || o_bd !== 1'b0) begin
            failures++; $display("[TB] FAIL adel_payload: got pc=%h inst=%h bd=%b required pc=bfc00102 inst=0 bd=0", o_pc, o_inst, o_bd);
        end
`else
        assertions++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00100) begin
            failures++; $display("[TB] FAIL unaligned_addr: got req=%b addr=%h required req=1 addr=bfc00100", inst_req, inst_addr);
        end
        serve(0, 0);
        assertions++; if (o_pc !== 32'hBFC00102 || o_except !== 7'd0 || o_inst !== 32'h0100FEFF) begin
            failures++; $display("[TB] FAIL unaligned_fetch: got pc=%h exc=%h inst=%h required pc=bfc00102 exc=0 inst=0100feff", o_pc, o_except, o_inst);
        end
`endif
        flush = 1'b1;
        flush_pc = 32'hBFC00000;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic test_reset_mid_request();
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        inst_rdata = 32'hDEADBEEF;
        inst_data_ok = 1'b1;
        @(negedge clk);
        inst_data_ok = 1'b0;
        assertions++; if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL late_data_valid: got %b required 0", o_valid); end
        assertions++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00000) begin
            failures++; $display("[TB] FAIL reset_mid_req: got req=%b addr=%h required req=1 addr=bfc00000", inst_req, inst_addr);
        end
        serve(0, 2);
        assertions++; if (o_pc !== 32'hBFC00000 || o_inst !== 32'h24010001) begin
            failures++; $display("[TB] FAIL reset_mid_fetch: got pc=%h inst=%h required pc=bfc00000 inst=24010001", o_pc, o_inst);
        end
        pass_to_decode(2'b00, 1'b0);
    endtask

    task automatic test_random_latency();
        logic [31:0] exp_pc, saved_tgt, tgt;
        logic        exp_bd, pend, take;
        exp_pc = 32'hBFC00004;
        exp_bd = 1'b0;
        pend = 1'b0;
        saved_tgt = 32'd0;
        req_in_wait = 0;
        for (int i = 0; i < 30; i++) begin
            serve(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            assertions++; if (o_valid !== 1'b1 || o_pc !== exp_pc) begin
                failures++; $display("[TB] FAIL rand_pc[%0d]: got v=%b pc=%h required v=1 pc=%h", i, o_valid, o_pc, exp_pc);
            end
            assertions++; if (o_inst !== inst_of(exp_pc) || o_bd !== exp_bd) begin
                failures++; $display("[TB] FAIL rand_inst[%0d]: got inst=%h bd=%b required inst=%h bd=%b", i, o_inst, o_bd, inst_of(exp_pc), exp_bd);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            take = !pend && ($urandom_range(0, 3) == 0);
            tgt = 32'hBFC01000 + ($urandom_range(0, 255) << 2);
            bpc = tgt;
            pass_to_decode(take ? 2'b01 : 2'b00, take);
            exp_bd = take;
            if (pend) begin
                exp_pc = saved_tgt;
                pend = 1'b0;
            end else begin
                exp_pc = exp_pc + 32'd4;
                if (take) begin
                    pend = 1'b1;
                    saved_tgt = tgt;
                end
            end
        end
        assertions++; if (req_in_wait !== 0) begin failures++; $display("[TB] FAIL single_outstanding: got %0d requests while waiting required 0", req_in_wait); end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_branch_delay_slot();
        test_flush_wait();
        test_flush_with_transfer();
        test_misaligned_jr();
        test_reset_mid_request();
        test_random_latency();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
